uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Receive-side UART deframer: the counterpart of the uart_core TX path. Oversamples the serial rx line
//  on an NCO tick, validates start bit, shifts in 8 data bits LSB-first, checks optional parity and
//  stop bit, and presents each byte on a valid/ready interface with a 1-entry holding register.
//  Sits between the pad-side rx pin and the RX FIFO; raises 1-cycle error/overflow pulses for the intr logic.
// PARAMETERS
//  OVS          16  ticks per bit (power of 2, >=4); data/stop sampled at tick OVS/2 of each bit
//  SYNC_STAGES  2   flops in rx synchronizer (>=2)
// PORTS
//  clk_i              in   1  clock
//  rst_i              in   1  async reset, active-high
//  tick_i             in   1  oversample strobe, 1-cycle pulse, OVS per bit
//  rx_i               in   1  serial line, async, idle high
//  rx_en_i            in   1  receiver enable
//  parity_en_i        in   1  parity bit present (used only with UART_RX_PARITY_EN)
//  parity_odd_i       in   1  1=odd, 0=even parity (used only with UART_RX_PARITY_EN)
//  rx_data_o          out  8  received byte, stable while rx_valid_o
//  rx_valid_o         out  1  byte available; held until rx_ready_i
//  rx_ready_i         in   1  consumer accepts byte when valid&&ready
//  busy_o             out  1  state != IDLE
//  intr_frame_err_o   out  1  1-cycle pulse: stop bit sampled 0
//  intr_parity_err_o  out  1  1-cycle pulse: parity mismatch (tied 0 without macro)
//  intr_break_err_o   out  1  1-cycle pulse: all data bits, parity (if present) and stop sampled 0
//  intr_overflow_o    out  1  1-cycle pulse: frame completed while holding reg full and not drained
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, sync flops 1, rx_data_o 0, rx_valid_o 0, busy_o 0, all intr 0.
//  - FSM advances only on tick_i=1 cycles (except IDLE exit on rx_en_i=0). States:
//    IDLE: on tick with synced rx=0 and previous synced rx=1 -> START, cnt=1.
//    START: at cnt==OVS/2 re-sample: rx=0 -> DATA (cnt=0, bit=0); rx=1 -> IDLE (glitch, no flag).
//    DATA: sample at each cnt==OVS-1 wrap (i.e. mid-bit), shift into data[bit]; after bit 7 ->
//      PARITY if parity enabled else STOP.
//    PARITY: mid-bit sample; error if (^data ^ p) != parity_odd_i.
//    STOP: mid-bit sample -> IDLE same tick; frame complete.
//  - Completion cycle (clock after stop sample tick): stop=0 -> frame_err pulse; break condition ->
//    break_err pulse in addition to frame_err; parity_err pulse; byte loaded even with errors.
//  - Holding reg: load sets rx_valid_o. If valid&&!ready at completion -> keep old byte, overflow pulse.
//    If valid&&ready same cycle as completion -> new byte loaded, valid stays 1, no overflow.
//  - Latency: rx_valid_o rises 1 clk after the stop-bit sampling tick; +SYNC_STAGES clk from pin.
//  - After frame_err, new start requires synced rx to return high (edge detect), so a held break
//    yields exactly one frame.
//  - rx_en_i=0: FSM forced to IDLE next clk, partial frame discarded, no flags; holding reg retained.
//  - Async reset mid-frame: immediate return to reset values; partial byte lost.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, parity_en_i/parity_odd_i honoured.
//  Not defined: no PARITY state, parity inputs ignored, intr_parity_err_o tied 0; 10-bit frames only.
// STRUCTURE
//  uart_rx_pkg: rx_state_e enum (IDLE,START,DATA,PARITY,STOP), UART_DATA_W=8 constant.
//  Sub-module uart_rx_sync: SYNC_STAGES-deep reset-to-1 synchronizer for rx_i.
// TESTING (tick_i=1 every clk, OVS=16 -> 16 clk/bit)
//  1. Frame 0x55 (start 0, 1010_1010 LSB-first, stop 1), ready=1 -> rx_data_o=0x55, valid 1 cycle, no intr.
//  2. 0.25-bit low glitch on idle line -> returns IDLE, busy_o drops, no valid, no intr.
//  3. 0xA3 with stop bit 0 -> valid, rx_data_o=0xA3, intr_frame_err_o pulse; break_err 0.
//  4. rx held low 20 bit times -> one byte 0x00, frame_err+break_err pulse once; next 0x55 after
//     line high received clean.
//  5. ready=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, overflow pulse; ready=1 coincident with
//     3rd frame 0x33 completion -> 0x33 loaded, no overflow.
//  6. UART_RX_PARITY_EN, parity_en=1, odd: 0x07 with p=0 -> ok; p=1 -> parity_err pulse; reset
//     asserted mid-DATA -> all outputs 0, next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deframer.
package uart_rx_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // An odd-parity frame has an odd number of ones across data and parity bit.
    function automatic logic parity_mismatch(input logic [UART_DATA_W-1:0] data,
                                             input logic                   par_bit,
                                             input logic                   odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte stream handshake between the deframer (master) and the RX FIFO (slave).
interface uart_rx_deframer_if;
    import uart_rx_pkg::*;

    logic [UART_DATA_W-1:0] rx_data_o;
    logic                   rx_valid_o;
    logic                   rx_ready_i;

    modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
    modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the async rx pin; resets to the idle-high line level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
    assign rx_sync_o = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= sync_d;
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/parity/stop recovery into a 1-entry holding register.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_deframer
    import uart_rx_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic                rx_i,
    input  logic                rx_en_i,
    input  logic                parity_en_i,
    input  logic                parity_odd_i,
    uart_rx_deframer_if.master  rx_if,
    output logic                busy_o,
    output logic                intr_frame_err_o,
    output logic                intr_parity_err_o,
    output logic                intr_break_err_o,
    output logic                intr_overflow_o
);

    localparam int              CNT_W    = $clog2(OVS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);

    logic rx_s;
    logic par_en;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (rx_i),
        .rx_sync_o (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    assign par_en = parity_en_i;
`else
    logic unused_parity_cfg;
    assign par_en            = 1'b0;
    assign unused_parity_cfg = parity_en_i ^ parity_odd_i;
`endif

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   rx_prev_q, rx_prev_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_q, par_err_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_q, frame_d;
    logic                   parity_q, parity_d;
    logic                   break_q, break_d;
    logic                   ovf_q, ovf_d;
    logic                   done;
    logic                   stop_bit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_prev_q <= 1'b1;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            break_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_prev_q <= rx_prev_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
            break_q   <= break_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        done      = 1'b0;
        stop_bit  = 1'b1;
        // The previous level only advances on ticks, so a line still low after a
        // broken frame cannot be mistaken for a fresh falling edge.
        rx_prev_d = tick_i ? rx_s : rx_prev_q;

        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    if (rx_en_i && !rx_s && rx_prev_q) begin
                        state_d   = START;
                        cnt_d     = CNT_ONE;
                        par_bit_d = 1'b0;
                        par_err_d = 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == 3'd7) state_d = par_en ? PARITY : STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_bit_d = rx_s;
                        par_err_d = parity_mismatch(shift_q, rx_s, parity_odd_i);
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        done     = 1'b1;
                        stop_bit = rx_s;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (!rx_en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end

        // Holding register: a completed frame overwrites only if the slot is free or draining now.
        data_d   = data_q;
        valid_d  = valid_q;
        frame_d  = 1'b0;
        parity_d = 1'b0;
        break_d  = 1'b0;
        ovf_d    = 1'b0;
        if (valid_q && rx_if.rx_ready_i) valid_d = 1'b0;
        if (done) begin
            frame_d  = !stop_bit;
            break_d  = !stop_bit && (shift_q == '0) && !par_bit_q;
            parity_d = par_err_q;
            if (valid_q && !rx_if.rx_ready_i) begin
                ovf_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy_o            = (state_q != IDLE);
        rx_if.rx_data_o   = data_q;
        rx_if.rx_valid_o  = valid_q;
        intr_frame_err_o  = frame_q;
        intr_parity_err_o = parity_q;
        intr_break_err_o  = break_q;
        intr_overflow_o   = ovf_q;
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer with OVS=16 and tick_i held high (16 clocks per bit).
module tb_uart_rx_deframer;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic tick    = 1'b1;
    logic rx      = 1'b1;
    logic rx_en   = 1'b1;
    logic par_en  = 1'b0;
    logic par_odd = 1'b0;
    logic busy, ferr, perr, berr, ovf;

    uart_rx_deframer_if bif();

    uart_rx_deframer #(.OVS(16), .SYNC_STAGES(2)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .tick_i            (tick),
        .rx_i              (rx),
        .rx_en_i           (rx_en),
        .parity_en_i       (par_en),
        .parity_odd_i      (par_odd),
        .rx_if             (bif),
        .busy_o            (busy),
        .intr_frame_err_o  (ferr),
        .intr_parity_err_o (perr),
        .intr_break_err_o  (berr),
        .intr_overflow_o   (ovf)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
    localparam int PX = 2;
    localparam int PE = 1;
`else
    localparam int PX = 0;
    localparam int PE = 0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int hs_cnt = 0, vcyc = 0, fcnt = 0, pcnt = 0, bcnt = 0, ocnt = 0;
    int lat    = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge clk) begin
        if (bif.rx_valid_o && bif.rx_ready_i) begin
            hs_cnt    <= hs_cnt + 1;
            last_byte <= bif.rx_data_o;
        end
        if (bif.rx_valid_o) vcyc <= vcyc + 1;
        if (ferr) fcnt <= fcnt + 1;
        if (perr) pcnt <= pcnt + 1;
        if (berr) bcnt <= bcnt + 1;
        if (ovf)  ocnt <= ocnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic has_par, input logic p);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rx = p;
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bif.rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, bif.rx_valid_o}, 0);
        chk("rst_data", {24'd0, bif.rx_data_o}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_intr", {28'd0, ferr, perr, berr, ovf}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: clean 0x55, valid rises 155 clocks after the start bit hits the pin
        fork
            send(8'h55, 1'b1, 1'b0, 1'b0);
            begin
                lat = 0;
                while (!bif.rx_valid_o && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        repeat (8) @(negedge clk);
        chk("t1_latency", lat, 155);
        chk("t1_hs", hs_cnt, 1);
        chk("t1_byte", {24'd0, last_byte}, 32'h55);
        chk("t1_vcyc", vcyc, 1);
        chk("t1_intr", fcnt + pcnt + bcnt + ocnt, 0);

        // 2: quarter-bit glitch is rejected at the start-bit re-sample
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_busy_hi", {31'd0, busy}, 1);
        repeat (30) @(negedge clk);
        chk("t2_busy_lo", {31'd0, busy}, 0);
        chk("t2_hs", hs_cnt, 1);
        chk("t2_intr", fcnt + pcnt + bcnt + ocnt, 0);

        // 3: stop bit low gives frame error but not break
        send(8'hA3, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("t3_hs", hs_cnt, 2);
        chk("t3_byte", {24'd0, last_byte}, 32'hA3);
        chk("t3_ferr", fcnt, 1);
        chk("t3_berr", bcnt, 0);

        // 4: long break yields exactly one frame, then clean traffic resumes
        rx = 1'b0;
        repeat (320) @(negedge clk);
        chk("t4_hs", hs_cnt, 3);
        chk("t4_byte", {24'd0, last_byte}, 32'h00);
        chk("t4_ferr", fcnt, 2);
        chk("t4_berr", bcnt, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        send(8'h55, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("t4_hs2", hs_cnt, 4);
        chk("t4_byte2", {24'd0, last_byte}, 32'h55);
        chk("t4_ferr2", fcnt, 2);
        chk("t4_berr2", bcnt, 1);

        // 5: overflow with ready low, then drain coincident with completion
        bif.rx_ready_i = 1'b0;
        send(8'h11, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_valid1", {31'd0, bif.rx_valid_o}, 1);
        chk("t5_data1", {24'd0, bif.rx_data_o}, 32'h11);
        chk("t5_ovf0", ocnt, 0);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_data2", {24'd0, bif.rx_data_o}, 32'h11);
        chk("t5_ovf1", ocnt, 1);
        fork
            send(8'h33, 1'b1, 1'b0, 1'b0);
            begin
                repeat (154) @(negedge clk);
                bif.rx_ready_i = 1'b1;
                @(negedge clk);
                bif.rx_ready_i = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("t5_data3", {24'd0, bif.rx_data_o}, 32'h33);
        chk("t5_valid3", {31'd0, bif.rx_valid_o}, 1);
        chk("t5_ovf_same", ocnt, 1);
        chk("t5_hs", hs_cnt, 5);
        chk("t5_hs_byte", {24'd0, last_byte}, 32'h11);
        bif.rx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_drained", {31'd0, bif.rx_valid_o}, 0);
        chk("t5_hs2", hs_cnt, 6);
        chk("t5_byte_last", {24'd0, last_byte}, 32'h33);

`ifdef UART_RX_PARITY_EN
        // 6a: odd parity, 0x07 has three ones so p=0 is correct and p=1 is wrong
        par_en  = 1'b1;
        par_odd = 1'b1;
        send(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_par_ok_byte", {24'd0, last_byte}, 32'h07);
        chk("t6_par_ok", pcnt, 0);
        send(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_par_err", pcnt, 1);
        chk("t6_par_err_ferr", fcnt, 2);
`endif

        // 6b: async reset in the middle of the data bits
        bif.rx_ready_i = 1'b0;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_busy_pre", {31'd0, busy}, 1);
        chk("t6_data_pre", {24'd0, bif.rx_data_o}, (PE != 0) ? 32'h07 : 32'h33);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_data", {24'd0, bif.rx_data_o}, 0);
        chk("t6_rst_valid", {31'd0, bif.rx_valid_o}, 0);
        chk("t6_rst_intr", {28'd0, ferr, perr, berr, ovf}, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_idle_busy", {31'd0, busy}, 0);
        chk("t6_idle_hs", hs_cnt, 6 + PX);
        bif.rx_ready_i = 1'b1;
        send(8'h5A, 1'b1, par_en, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_5a_byte", {24'd0, last_byte}, 32'h5A);
        chk("t6_5a_hs", hs_cnt, 7 + PX);
        chk("t6_ferr_total", fcnt, 2);
        chk("t6_perr_total", pcnt, PE);
        chk("t6_berr_total", bcnt, 1);
        chk("t6_ovf_total", ocnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
